execute_writeback_unit: RTL and testbench
=========================================

EXECUTE_WRITEBACK_UNIT -- requirements
Module: execute_writeback_unit

Interface
REQ-001 Parameter: WIDTH, 64, datapath width; matches the 32x64 register file.
REQ-002 Parameter: ADDR, 5, register-index width.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of clock.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 FS  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LSL, 110 LSR, 111 MUL.
REQ-007 A  input  WIDTH  operand A, from register-file read bus A.
REQ-008 B  input  WIDTH  operand B, from register-file read bus B.
REQ-009 DA  input  ADDR  destination register index.
REQ-010 data  output  WIDTH  write-back value; drives register-file data input.
REQ-011 SI  output  ADDR  write-back index; drives register-file SI.
REQ-012 load  output  1  write enable; drives register-file load.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 flags  output  4  {N,Z,C,V}, registered.

Function
REQ-016 FSM states are IDLE, EXEC, MUL and WB; all outputs are registered.
REQ-017 In IDLE, start=1 at edge N captures A, B, FS and DA, then moves to MUL if FS=111, else to EXEC.
REQ-018 start while busy=1 is ignored: no queuing, no effect on the operation in progress.
REQ-019 At edge N+1, EXEC registers the result into data, DA into SI and updates flags, then moves to WB.
REQ-020 MUL is shift-add over 64 iterations counted 0..63; at the edge where count=63 (edge N+64) it registers the result, SI and flags, then moves to WB.
REQ-021 WB lasts exactly one cycle: done=1; load=1 unless SI=31; the next edge returns to IDLE with load=0 and done=0.
REQ-022 A start asserted in the IDLE cycle that follows WB is accepted, so back-to-back issue gap is one IDLE cycle.
REQ-023 Latency: non-MUL load high after edge N+1 (register file writes at N+2); MUL load high after edge N+64.
REQ-024 DA=31 (XZR) suppresses load but still pulses done and updates data and flags.
REQ-025 ADD gives (A+B) mod 2^64; C is the carry-out; V is set when the operand signs match and the result sign differs.
REQ-026 SUB computes A+~B+1; C=1 when A>=B unsigned; V is signed overflow.
REQ-027 AND/OR/XOR are bitwise, with C=0 and V=0.
REQ-028 LSL/LSR shift A by B[5:0], zero-filling, with B[63:6] ignored; a shift of 0 returns A; C=0 and V=0.
REQ-029 MUL returns the low 64 bits of A*B (signedness irrelevant), with C=0 and V=0.
REQ-030 For every op, N=result[63] and Z=(result==0).
REQ-031 Operand changes on A and B after capture do not affect the result.
REQ-032 data, SI and flags hold their last values in IDLE.

Reset
REQ-033 reset=0 forces IDLE, data=0, SI=0, flags=0, load=0, done=0, busy=0 and the MUL counter=0, asynchronously.
REQ-034 Reset mid-operation abandons the operation: no load and no done pulse follow.
REQ-035 The first start is accepted at the first rising edge with reset=1.

Verification
REQ-036 ADD, A=FFFF_FFFF_FFFF_FFFF, B=1, DA=3 -> data=0, SI=3, load=1 for one cycle, flags N=0 Z=1 C=1 V=0.
REQ-037 SUB, A=8000_0000_0000_0000, B=1, DA=5 -> data=7FFF_FFFF_FFFF_FFFF, flags N=0 Z=0 C=1 V=1.
REQ-038 MUL, A=0000_0001_0000_0001, B=3, DA=7 -> data=0000_0003_0000_0003, SI=7, load high after edge N+64 for exactly one cycle, busy high for 65 cycles.
REQ-039 XOR, A=B=any, DA=31 -> done pulses, load stays 0, Z=1.
REQ-040 MUL in progress, start held high with FS=000 -> MUL result unaffected; ADD accepted one IDLE cycle after WB.
REQ-041 reset=0 at iteration 10 of a MUL -> busy, load and data go to 0 immediately; no load is ever seen for that operation.

Source files
------------

// File: rtl/execute_writeback_unit_if.sv
// Issue/write-back bundle between the register-file read side and the execute/write-back unit.
// The requester drives the master side and the unit implements the slave side.
interface execute_writeback_unit_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned ADDR  = 5
);
    logic             start;
    logic [2:0]       FS;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [ADDR-1:0]  DA;
    logic [WIDTH-1:0] data;
    logic [ADDR-1:0]  SI;
    logic             load;
    logic             busy;
    logic             done;
    logic [3:0]       flags;

    modport master (
        output start, FS, A, B, DA,
        input  data, SI, load, busy, done, flags
    );

    modport slave (
        input  start, FS, A, B, DA,
        output data, SI, load, busy, done, flags
    );
endinterface

// File: rtl/execute_writeback_unit.sv
// Multi-cycle ALU with a shift-add multiplier that writes one result back into the register file.
// Every output is registered, and the unit runs one operation at a time with no queuing.
module execute_writeback_unit #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned ADDR  = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    execute_writeback_unit_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [ADDR-1:0] Xzr = {ADDR{1'b1}};

    typedef enum logic [1:0] {StIdle, StExec, StMul, StWb} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, data_q, data_d;
    logic [2:0]       fs_q, fs_d;
    logic [ADDR-1:0]  da_q, da_d, si_q, si_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [3:0]       flags_q, flags_d;
    logic             load_q, load_d, done_q, done_d, busy_q, busy_d;

    logic [WIDTH-1:0] alu_res, mul_sum;
    logic [WIDTH:0]   add_w, sub_w;
    logic             alu_c, alu_v;
    logic [CntW-1:0]  shamt;

    always_comb begin
        add_w   = {1'b0, a_q} + {1'b0, b_q};
        sub_w   = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
        shamt   = b_q[CntW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (fs_q)
            3'b000: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b001: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b010:  alu_res = a_q & b_q;
            3'b011:  alu_res = a_q | b_q;
            3'b100:  alu_res = a_q ^ b_q;
            3'b101:  alu_res = a_q << shamt;
            3'b110:  alu_res = a_q >> shamt;
            default: alu_res = '0;
        endcase
    end

    // Multiplicand shifts left and multiplier shifts right each iteration.
    assign mul_sum = acc_q + (b_q[0] ? a_q : '0);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fs_d    = fs_q;
        da_d    = da_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        si_d    = si_q;
        flags_d = flags_q;
        load_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    fs_d    = bus.FS;
                    da_d    = bus.DA;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (bus.FS == 3'b111) ? StMul : StExec;
                end
            end
            StExec: begin
                data_d  = alu_res;
                si_d    = da_q;
                flags_d = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
                load_d  = (da_q != Xzr);
                done_d  = 1'b1;
                state_d = StWb;
            end
            StMul: begin
                acc_d = mul_sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    data_d  = mul_sum;
                    si_d    = da_q;
                    flags_d = {mul_sum[WIDTH-1], mul_sum == '0, 2'b00};
                    load_d  = (da_q != Xzr);
                    done_d  = 1'b1;
                    state_d = StWb;
                end
            end
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            fs_q    <= '0;
            da_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            si_q    <= '0;
            flags_q <= '0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fs_q    <= fs_d;
            da_q    <= da_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            si_q    <= si_d;
            flags_q <= flags_d;
            load_q  <= load_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.data  = data_q;
    assign bus.SI    = si_q;
    assign bus.flags = flags_q;
    assign bus.load  = load_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_execute_writeback_unit.sv
// Bench for execute_writeback_unit: a transaction-level reference model checked every cycle,
// plus directed operations whose results are pinned to hand-computed literals.
module tb_execute_writeback_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    execute_writeback_unit_if #(.WIDTH(64), .ADDR(5)) bus ();

    execute_writeback_unit #(.WIDTH(64), .ADDR(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result as {N,Z,C,V,result}, from plain wide arithmetic.
    function automatic logic [67:0] ref_op(input logic [2:0] fs, input logic [63:0] a,
                                           input logic [63:0] b);
        logic [63:0]  r;
        logic         c, v;
        logic [127:0] sa, sb, sx, ua;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        c  = 1'b0;
        v  = 1'b0;
        case (fs)
            3'd0: begin
                r  = a + b;
                ua = {64'b0, a} + {64'b0, b};
                c  = (ua[127:64] != 64'b0);
                sx = sa + sb;
                v  = (sx != {{64{sx[63]}}, sx[63:0]});
            end
            3'd1: begin
                r  = a - b;
                c  = (a >= b);
                sx = sa - sb;
                v  = (sx != {{64{sx[63]}}, sx[63:0]});
            end
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = a << b[5:0];
            3'd6:    r = a >> b[5:0];
            default: r = a * b;
        endcase
        return {r[63], r == 64'b0, c, v, r};
    endfunction

    logic        m_busy = 0, m_load = 0, m_done = 0;
    logic [63:0] m_data = 0, p_data = 0;
    logic [4:0]  m_si = 0, p_si = 0;
    logic [3:0]  m_flags = 0, p_flags = 0;
    int          m_left = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy <= 0; m_load <= 0; m_done <= 0;
            m_data <= 0; m_si <= 0; m_flags <= 0; m_left <= 0;
        end else if (m_done) begin
            m_done <= 0; m_load <= 0; m_busy <= 0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_data  <= p_data;
                m_si    <= p_si;
                m_flags <= p_flags;
                m_done  <= 1;
                m_load  <= (p_si != 5'd31);
            end
        end else if (bus.start) begin
            {p_flags, p_data} <= ref_op(bus.FS, bus.A, bus.B);
            p_si   <= bus.DA;
            m_left <= (bus.FS == 3'd7) ? 64 : 1;
            m_busy <= 1;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            chk("busy", {63'b0, bus.busy}, {63'b0, m_busy});
            chk("load", {63'b0, bus.load}, {63'b0, m_load});
            chk("done", {63'b0, bus.done}, {63'b0, m_done});
            chk("data", bus.data, m_data);
            chk("si", {59'b0, bus.SI}, {59'b0, m_si});
            chk("flags", {60'b0, bus.flags}, {60'b0, m_flags});
        end
    end

    task automatic start_op(input logic [2:0] fs, input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] da);
        @(negedge clock);
        bus.start = 1; bus.FS = fs; bus.A = a; bus.B = b; bus.DA = da;
    endtask

    // Call right after the start was driven; returns at the negedge where done is visible.
    task automatic wait_done(input int exp_lat, input bit hold_add, output int loads);
        int k = 0, busyc = 0;
        bit seen = 0;
        loads = 0;
        @(negedge clock);
        if (hold_add) begin
            bus.FS = 3'd0; bus.A = 64'd5; bus.B = 64'd6; bus.DA = 5'd9;
        end else begin
            bus.start = 0;
            bus.A = {$urandom, $urandom};
            bus.B = {$urandom, $urandom};
        end
        while (!seen && k < 200) begin
            if (k > 0) @(negedge clock);
            if (bus.busy) busyc++;
            if (bus.load) loads++;
            if (bus.done) begin
                seen = 1;
                chk("latency", 64'(k), 64'(exp_lat));
            end
            k++;
        end
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
        chk("busy_cycles", 64'(busyc), 64'(exp_lat + 1));
    endtask

    task automatic run(input string name, input logic [2:0] fs, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] da, input logic [63:0] exp_d,
                       input logic [3:0] exp_f);
        int loads;
        start_op(fs, a, b, da);
        wait_done((fs == 3'd7) ? 64 : 1, 0, loads);
        chk({name, "_data"}, bus.data, exp_d);
        chk({name, "_flags"}, {60'b0, bus.flags}, {60'b0, exp_f});
        chk({name, "_si"}, {59'b0, bus.SI}, {59'b0, da});
        chk({name, "_loads"}, 64'(loads), (da == 5'd31) ? 64'd0 : 64'd1);
    endtask

    initial begin
        int loads;
        bus.start = 0; bus.FS = 0; bus.A = 0; bus.B = 0; bus.DA = 0;
        #2 reset = 0;
        #1;
        chk("rst_busy", {63'b0, bus.busy}, 64'd0);
        chk("rst_load", {63'b0, bus.load}, 64'd0);
        chk("rst_done", {63'b0, bus.done}, 64'd0);
        chk("rst_data", bus.data, 64'd0);
        chk("rst_si", {59'b0, bus.SI}, 64'd0);
        chk("rst_flags", {60'b0, bus.flags}, 64'd0);

        // Start already high when reset releases: taken at the first live edge.
        @(negedge clock);
        #1;
        reset = 1;
        bus.start = 1; bus.FS = 3'd0; bus.A = 64'hFFFF_FFFF_FFFF_FFFF; bus.B = 64'd1; bus.DA = 5'd3;
        wait_done(1, 0, loads);
        chk("add_data", bus.data, 64'd0);
        chk("add_flags", {60'b0, bus.flags}, 64'b0110);
        chk("add_si", {59'b0, bus.SI}, 64'd3);
        chk("add_loads", 64'(loads), 64'd1);

        run("sub_ovf", 3'd1, 64'h8000_0000_0000_0000, 64'd1, 5'd5, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
        run("add_ovf", 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd1, 64'h8000_0000_0000_0000, 4'b1001);
        run("sub_neg", 3'd1, 64'd1, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
        run("and", 3'd2, 64'hF0F0, 64'hFF00, 5'd6, 64'hF000, 4'b0000);
        run("or", 3'd3, 64'hF0, 64'h0F, 5'd2, 64'hFF, 4'b0000);
        run("xor_xzr", 3'd4, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 5'd31, 64'd0, 4'b0100);
        run("lsl63", 3'd5, 64'd1, 64'h7F, 5'd8, 64'h8000_0000_0000_0000, 4'b1000);
        run("lsr0", 3'd6, 64'h1234, 64'h40, 5'd10, 64'h1234, 4'b0000);
        run("lsr63", 3'd6, 64'h8000_0000_0000_0000, 64'd63, 5'd11, 64'd1, 4'b0000);

        // MUL with start held high (as an ADD) throughout; the ADD lands one idle cycle after WB.
        start_op(3'd7, 64'h0000_0001_0000_0001, 64'd3, 5'd7);
        wait_done(64, 1, loads);
        chk("mul_data", bus.data, 64'h0000_0003_0000_0003);
        chk("mul_si", {59'b0, bus.SI}, 64'd7);
        chk("mul_loads", 64'(loads), 64'd1);
        @(negedge clock);
        chk("gap_idle", {63'b0, bus.busy}, 64'd0);
        wait_done(1, 0, loads);
        chk("held_add_data", bus.data, 64'd11);
        chk("held_add_si", {59'b0, bus.SI}, 64'd9);

        run("mul_m1", 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 64'd1, 4'b0000);
        repeat (3) @(negedge clock);

        // Reset at iteration 10 of a MUL: outputs clear at once and no write-back follows.
        start_op(3'd7, 64'h1234_5678, 64'h9ABC, 5'd13);
        @(negedge clock);
        bus.start = 0;
        repeat (10) @(negedge clock);
        #1 reset = 0;
        #1;
        chk("arst_busy", {63'b0, bus.busy}, 64'd0);
        chk("arst_load", {63'b0, bus.load}, 64'd0);
        chk("arst_data", bus.data, 64'd0);
        repeat (2) @(negedge clock);
        #1 reset = 1;
        loads = 0;
        repeat (80) begin
            @(negedge clock);
            if (bus.load || bus.done) loads++;
        end
        chk("arst_no_wb", 64'(loads), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
